// File: rtl/frame_read_sequencer.sv
// Read-phase sequencer: requests a frame from the camera FIFO, streams WIDTH x HEIGHT bytes
// through vref/href and emits raster-ordered pixel writes for the left then the right image.
module frame_read_sequencer #(
  parameter int WIDTH  = 47,
  parameter int HEIGHT = 30,
  parameter int XW     = 6,
  parameter int YW     = 5,
  parameter int GAP    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          buffer_ready,
  input  logic [7:0]    image_data,
  output logic          new_image,
  output logic          buffer_vref,
  output logic          buffer_href,
  output logic          image_sel,
  output logic          pix_we,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [7:0]    pix_data,
  output logic          busy,
  output logic          done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_VSYNC    = 3'd3,
    S_ROW      = 3'd4,
    S_GAP      = 3'd5,
    S_FIN      = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            sel_q, sel_d;
  logic            href_s;

  logic            new_image_q, vref_q, busy_q, done_q;
  logic            pix_we_q;
  logic [XW-1:0]   pix_x_q;
  logic [YW-1:0]   pix_y_q;

  // Next-state, pixel counters and FIFO read enable.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    gap_d   = gap_q;
    sel_d   = sel_q;
    href_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (buffer_ready) begin
          state_d = S_VSYNC;
        end else begin
          state_d = S_WAIT_RDY;
        end
      end
      S_VSYNC: begin
        x_d     = {XW{1'b0}};
        y_d     = {YW{1'b0}};
        state_d = S_ROW;
      end
      S_ROW: begin
        // A low buffer_ready stalls the stream with coordinates frozen.
        href_s = buffer_ready;
        if (buffer_ready) begin
          if (x_q == X_LAST) begin
            x_d = {XW{1'b0}};
            if (y_q == Y_LAST) begin
              if (sel_q) begin
                state_d = S_FIN;
              end else begin
                sel_d   = 1'b1;
                state_d = S_REQ;
              end
            end else begin
              y_d     = y_q + YW'(1);
              gap_d   = {GW{1'b0}};
              state_d = S_GAP;
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          state_d = S_ROW;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_ROW;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_FIN: begin
        sel_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= {XW{1'b0}};
      y_q     <= {YW{1'b0}};
      gap_q   <= {GW{1'b0}};
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
    end
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      new_image_q <= 1'b0;
      vref_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      new_image_q <= (state_d == S_REQ);
      vref_q      <= (state_d == S_VSYNC);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
    end
  end

  // Write path: FIFO data arrives one cycle after its href, so coordinates trail by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_we_q <= 1'b0;
      pix_x_q  <= {XW{1'b0}};
      pix_y_q  <= {YW{1'b0}};
    end else begin
      pix_we_q <= href_s;
      if (href_s) begin
        pix_x_q <= x_q;
        pix_y_q <= y_q;
      end else begin
        pix_x_q <= pix_x_q;
        pix_y_q <= pix_y_q;
      end
    end
  end

  assign new_image   = new_image_q;
  assign buffer_vref = vref_q;
  assign buffer_href = href_s;
  assign image_sel   = sel_q;
  assign pix_we      = pix_we_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_we_q ? image_data : 8'd0;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
